// File: rtl/RV_pkg.sv
// RV_pkg: shared memory-op encodings and the data-memory arbiter state type.
package RV_pkg;
    typedef enum logic {MEMOP_READ = 1'b0, MEMOP_WRITE = 1'b1} MemOpType;
    typedef enum logic [1:0] {MEMSIZE_BYTE = 2'd0, MEMSIZE_HALF = 2'd1, MEMSIZE_WORD = 2'd2} MemSizeType;
    typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2} DmemArbStateType;
endpackage

// File: rtl/rv_dmem_arbiter.sv
// rv_dmem_arbiter: two-master arbiter for the split address/data memory port with a hang watchdog.
module rv_dmem_arbiter
    import RV_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256,
    parameter bit FIXED_PRIO     = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_addr_vld,
    input  logic [31:0] m0_addr,
    input  logic        m0_op,
    input  logic [1:0]  m0_size,
    input  logic        m0_wdata_vld,
    input  logic [31:0] m0_wdata,
    output logic        m0_addr_rsp,
    output logic        m0_data_rsp,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    input  logic        m1_addr_vld,
    input  logic [31:0] m1_addr,
    input  logic        m1_op,
    input  logic [1:0]  m1_size,
    input  logic        m1_wdata_vld,
    input  logic [31:0] m1_wdata,
    output logic        m1_addr_rsp,
    output logic        m1_data_rsp,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    output logic        mem_addr_vld,
    output logic [31:0] mem_addr,
    output logic        mem_op,
    output logic [1:0]  mem_size,
    output logic        mem_wdata_vld,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_rsp,
    input  logic        mem_data_rsp,
    input  logic [31:0] mem_rdata
);
    localparam int WdW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;

    DmemArbStateType state;
    logic            gnt;
    logic            rr_last;
    logic [WdW-1:0]  wd_cnt;
    logic            busy, inAddr, inData, timeout, done;
    logic            addrRsp, dataRsp, errPulse;
    logic [31:0]     rdata;
    logic            selAddrVld, selOp, selWdataVld;
    logic [31:0]     selAddr, selWdata;
    logic [1:0]      selSize;

    function automatic logic pickWinner(input logic r0, input logic r1, input logic last);
        return (r0 && r1) ? (FIXED_PRIO ? 1'b0 : !last) : (r1 && !r0);
    endfunction

    assign busy    = state != IDLE;
    assign inAddr  = state == ADDR;
    assign inData  = state == DATA;
    assign timeout = (TIMEOUT_CYCLES != 0) && busy && (wd_cnt == WdW'(TIMEOUT_CYCLES - 1));
    // An address phase only completes early when both responses coincide.
    assign done    = mem_data_rsp && (inData || (inAddr && mem_addr_rsp));

    assign addrRsp  = inAddr && (mem_addr_rsp || timeout);
    assign dataRsp  = done || timeout;
    assign errPulse = timeout && !done;
    assign rdata    = done ? mem_rdata : 32'h0;

    assign selAddrVld  = gnt ? m1_addr_vld  : m0_addr_vld;
    assign selAddr     = gnt ? m1_addr      : m0_addr;
    assign selOp       = gnt ? m1_op        : m0_op;
    assign selSize     = gnt ? m1_size      : m0_size;
    assign selWdataVld = gnt ? m1_wdata_vld : m0_wdata_vld;
    assign selWdata    = gnt ? m1_wdata     : m0_wdata;

    assign m0_addr_rsp = addrRsp && !gnt;
    assign m0_data_rsp = dataRsp && !gnt;
    assign m0_err      = errPulse && !gnt;
    assign m0_rdata    = gnt ? 32'h0 : rdata;
    assign m1_addr_rsp = addrRsp && gnt;
    assign m1_data_rsp = dataRsp && gnt;
    assign m1_err      = errPulse && gnt;
    assign m1_rdata    = gnt ? rdata : 32'h0;

    assign mem_addr_vld  = inAddr && selAddrVld && !timeout;
    assign mem_addr      = busy ? selAddr : 32'h0;
    assign mem_op        = busy && selOp;
    assign mem_size      = busy ? selSize : 2'b00;
    assign mem_wdata_vld = inData && selWdataVld;
    assign mem_wdata     = inData ? selWdata : 32'h0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            gnt     <= 1'b0;
            rr_last <= 1'b1;
            wd_cnt  <= '0;
        end else if (!busy) begin
            wd_cnt <= '0;
            if (m0_addr_vld || m1_addr_vld) begin
                gnt   <= pickWinner(m0_addr_vld, m1_addr_vld, rr_last);
                state <= ADDR;
            end
        end else begin
            wd_cnt <= wd_cnt + WdW'(1);
            if (done || timeout) begin
                state   <= IDLE;
                rr_last <= gnt;
            end else if (inAddr && mem_addr_rsp) begin
                state <= DATA;
            end
        end
    end

    // A data response before the address is accepted is a memory protocol error.
    assert property (@(posedge clk) disable iff (rst) !(inAddr && mem_data_rsp && !mem_addr_rsp));
endmodule

// File: tb/tb_rv_dmem_arbiter.sv
// tb_rv_dmem_arbiter: transaction-level model check of rv_dmem_arbiter plus directed scenarios.
module tb_rv_dmem_arbiter;
    import RV_pkg::*;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        mvld[2], mop[2], mwv[2];
    logic [31:0] maddr[2], mwd[2];
    logic [1:0]  msz[2];
    logic        ars[2][2], drs[2][2], er[2][2];
    logic [31:0] rdt[2][2];
    logic        mav[2], mopo[2], mwvo[2], mar[2], mdr[2];
    logic [31:0] mao[2], mwdo[2], mrd[2];
    logic [1:0]  mszo[2];

    int unsigned checks = 0, errors = 0;
    int          memMode = 1;
    logic [31:0] memRdata = 32'h0;
    bit          chkOn = 0, logOn = 0;
    int          log0[$], logF[$];

    rv_dmem_arbiter #(.TIMEOUT_CYCLES(TO), .FIXED_PRIO(1'b0)) dut (
        .clk(clk), .rst(rst),
        .m0_addr_vld(mvld[0]), .m0_addr(maddr[0]), .m0_op(mop[0]), .m0_size(msz[0]),
        .m0_wdata_vld(mwv[0]), .m0_wdata(mwd[0]),
        .m0_addr_rsp(ars[0][0]), .m0_data_rsp(drs[0][0]), .m0_rdata(rdt[0][0]), .m0_err(er[0][0]),
        .m1_addr_vld(mvld[1]), .m1_addr(maddr[1]), .m1_op(mop[1]), .m1_size(msz[1]),
        .m1_wdata_vld(mwv[1]), .m1_wdata(mwd[1]),
        .m1_addr_rsp(ars[0][1]), .m1_data_rsp(drs[0][1]), .m1_rdata(rdt[0][1]), .m1_err(er[0][1]),
        .mem_addr_vld(mav[0]), .mem_addr(mao[0]), .mem_op(mopo[0]), .mem_size(mszo[0]),
        .mem_wdata_vld(mwvo[0]), .mem_wdata(mwdo[0]),
        .mem_addr_rsp(mar[0]), .mem_data_rsp(mdr[0]), .mem_rdata(mrd[0])
    );

    rv_dmem_arbiter #(.TIMEOUT_CYCLES(TO), .FIXED_PRIO(1'b1)) dutF (
        .clk(clk), .rst(rst),
        .m0_addr_vld(mvld[0]), .m0_addr(maddr[0]), .m0_op(mop[0]), .m0_size(msz[0]),
        .m0_wdata_vld(mwv[0]), .m0_wdata(mwd[0]),
        .m0_addr_rsp(ars[1][0]), .m0_data_rsp(drs[1][0]), .m0_rdata(rdt[1][0]), .m0_err(er[1][0]),
        .m1_addr_vld(mvld[1]), .m1_addr(maddr[1]), .m1_op(mop[1]), .m1_size(msz[1]),
        .m1_wdata_vld(mwv[1]), .m1_wdata(mwd[1]),
        .m1_addr_rsp(ars[1][1]), .m1_data_rsp(drs[1][1]), .m1_rdata(rdt[1][1]), .m1_err(er[1][1]),
        .mem_addr_vld(mav[1]), .mem_addr(mao[1]), .mem_op(mopo[1]), .mem_size(mszo[1]),
        .mem_wdata_vld(mwvo[1]), .mem_wdata(mwdo[1]),
        .mem_addr_rsp(mar[1]), .mem_data_rsp(mdr[1]), .mem_rdata(mrd[1])
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Memory: mode 0 silent, 1 addr after one wait then data next cycle, 2 both at once, 3 addr only.
    initial begin
        int  aw[2];
        bit  pend[2];
        for (int k = 0; k < 2; k++) begin
            aw[k] = 0; pend[k] = 0; mar[k] = 0; mdr[k] = 0; mrd[k] = 0;
        end
        forever begin
            @(negedge clk);
            #1;
            for (int k = 0; k < 2; k++) begin
                mar[k] = 0; mdr[k] = 0; mrd[k] = memRdata;
                if (rst) begin
                    aw[k] = 0; pend[k] = 0;
                end else if (pend[k]) begin
                    mdr[k] = 1; pend[k] = 0;
                end else if (mav[k]) begin
                    if (memMode == 2) begin
                        mar[k] = 1; mdr[k] = 1;
                    end else if (memMode == 3 || (memMode == 1 && aw[k] >= 1)) begin
                        mar[k] = 1; pend[k] = (memMode == 1);
                    end
                    aw[k] = mar[k] ? 0 : aw[k] + 1;
                end else begin
                    aw[k] = 0;
                end
            end
        end
    end

    // Transaction-level model of the arbiter seen from the masters and the memory port.
    bit busy = 0, acc = 0;
    int owner = 0, age = 0, last = 1;
    initial forever begin
        logic [34:0] expM[2];
        logic [66:0] expMem;
        bit tmo, inA, comp;
        @(negedge clk);
        #3;
        tmo  = busy && (age == TO - 1);
        inA  = busy && !acc;
        comp = busy && mdr[0] && (acc || mar[0]);
        for (int m = 0; m < 2; m++) begin
            bit mine;
            mine = busy && owner == m;
            expM[m] = {mine && inA && (mar[0] || tmo), mine && (comp || tmo),
                       mine && tmo && !comp, (mine && comp) ? mrd[0] : 32'h0};
        end
        expMem = busy ? {inA && mvld[owner] && !tmo, maddr[owner], mop[owner],
                         acc && mwv[owner], acc ? mwd[owner] : 32'h0} : 67'h0;
        if (chkOn) begin
            chk("m0 outputs", {ars[0][0], drs[0][0], er[0][0], rdt[0][0]}, expM[0]);
            chk("m1 outputs", {ars[0][1], drs[0][1], er[0][1], rdt[0][1]}, expM[1]);
            chk("mem outputs", {mav[0], mao[0], mopo[0], mwvo[0], mwdo[0]}, expMem);
        end
        if (logOn) begin
            for (int m = 0; m < 2; m++) begin
                if (drs[0][m]) log0.push_back(m);
                if (drs[1][m]) logF.push_back(m);
            end
        end
        if (rst) begin
            busy = 0; last = 1;
        end else if (!busy) begin
            if (mvld[0] || mvld[1]) begin
                busy = 1; acc = 0; age = 0;
                owner = (mvld[0] && mvld[1]) ? 1 - last : (mvld[1] ? 1 : 0);
            end
        end else begin
            age++;
            if (comp || tmo) begin
                busy = 0; last = owner;
            end else if (inA && mar[0]) begin
                acc = 1;
            end
        end
    end

    task automatic run(input int m, input logic [31:0] a, input logic op, input logic [31:0] wd,
                       output int cyc, output logic [31:0] rd, output logic e, output logic aDone,
                       output logic [66:0] snap, output logic [34:0] other);
        bit done = 0, gotA = 0;
        mvld[m] = 1; maddr[m] = a; mop[m] = op; msz[m] = MEMSIZE_WORD; mwv[m] = op; mwd[m] = wd;
        cyc = 0; rd = 0; e = 0; aDone = 0; snap = 0; other = 0;
        while (!done && cyc < 40) begin
            #3;
            cyc++;
            if (ars[0][m]) gotA = 1;
            if (drs[0][m]) begin
                done = 1; rd = rdt[0][m]; e = er[0][m]; aDone = ars[0][m];
                snap  = {mav[0], mao[0], mopo[0], mwvo[0], mwdo[0]};
                other = {ars[0][1-m], drs[0][1-m], er[0][1-m], rdt[0][1-m]};
            end
            @(negedge clk);
            if (gotA) mvld[m] = 0;
        end
        mwv[m] = 0;
        chk("txn completes in bound", done, 1);
    endtask

    function automatic logic [3:0] order(input int q[$]);
        logic [3:0] g;
        for (int i = 0; i < 4; i++) g[3-i] = (i < q.size()) ? q[i][0] : 1'bx;
        return g;
    endfunction

    initial begin
        int cyc;
        logic [31:0] rd;
        logic e, aDone;
        logic [66:0] snap;
        logic [34:0] other;
        int first;
        for (int m = 0; m < 2; m++) begin
            mvld[m] = 0; mop[m] = 0; mwv[m] = 0; maddr[m] = 0; mwd[m] = 0; msz[m] = 0;
        end
        repeat (2) @(negedge clk);
        rst = 0; chkOn = 1;
        #3;
        chk("reset m0", {ars[0][0], drs[0][0], er[0][0], rdt[0][0]}, 0);
        chk("reset mem", {mav[0], mao[0], mopo[0], mszo[0], mwvo[0], mwdo[0]}, 0);
        @(negedge clk);

        memMode = 1; memRdata = 32'h11111111; logOn = 1;
        mvld[0] = 1; maddr[0] = 32'h40; mvld[1] = 1; maddr[1] = 32'h80; msz[0] = 2; msz[1] = 2;
        for (int i = 0; i < 60 && (log0.size() < 4 || logF.size() < 4); i++) @(negedge clk);
        logOn = 0;
        chk("rr grant order", order(log0), 4'b0101);
        chk("fixed grant order", order(logF), 4'b0000);
        rst = 1; mvld[0] = 0; mvld[1] = 0;
        @(negedge clk);
        rst = 0;

        memRdata = 32'hDEADBEEF;
        run(0, 32'h100, MEMOP_READ, 0, cyc, rd, e, aDone, snap, other);
        chk("read latency", cyc, 4);
        chk("read rdata", rd, 32'hDEADBEEF);
        chk("read err", e, 0);
        chk("read m1 idle", other, 0);

        run(1, 32'h200, MEMOP_WRITE, 32'h12345678, cyc, rd, e, aDone, snap, other);
        chk("write mem in DATA", snap, {1'b0, 32'h200, 1'b1, 1'b1, 32'h12345678});
        chk("write latency", cyc, 4);
        #3 chk("write rsp single pulse", drs[0][1], 0);
        @(negedge clk);

        memMode = 2;
        run(0, 32'h300, MEMOP_READ, 0, cyc, rd, e, aDone, snap, other);
        chk("coincident latency", cyc, 2);
        chk("coincident addr_rsp", aDone, 1);
        #3 chk("coincident back idle", mav[0], 0);
        @(negedge clk);

        memMode = 0; memRdata = 32'hCAFEF00D;
        run(0, 32'h400, MEMOP_READ, 0, cyc, rd, e, aDone, snap, other);
        chk("timeout cycle", cyc, 1 + TO);
        chk("timeout err", e, 1);
        chk("timeout rdata", rd, 0);
        chk("timeout addr_rsp", aDone, 1);
        memMode = 1;
        run(1, 32'h500, MEMOP_READ, 0, cyc, rd, e, aDone, snap, other);
        chk("after timeout latency", cyc, 4);
        chk("after timeout rdata", {e, rd}, {1'b0, 32'hCAFEF00D});

        memMode = 3;
        mvld[0] = 1; maddr[0] = 32'h600;
        @(negedge clk);
        @(negedge clk);
        mvld[0] = 0;
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        #3;
        chk("post-reset masters", {ars[0][0], drs[0][0], er[0][0], rdt[0][0],
                                   ars[0][1], drs[0][1], er[0][1], rdt[0][1]}, 0);
        chk("post-reset mem", {mav[0], mao[0], mopo[0], mszo[0], mwvo[0], mwdo[0]}, 0);
        @(negedge clk);
        memMode = 1; mvld[0] = 1; mvld[1] = 1; first = -1;
        for (int i = 0; i < 20 && first < 0; i++) begin
            #3;
            if (drs[0][0]) first = 0;
            else if (drs[0][1]) first = 1;
            @(negedge clk);
        end
        mvld[0] = 0; mvld[1] = 0;
        chk("post-reset tie winner", first, 0);
        repeat (6) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rv_dmem_arbiter.md
# rv_dmem_arbiter

Two-requester arbiter for the split address/data data-memory channel. The execute-stage LSU (master 0) and a second requester (master 1: debug/DMA/fetch-refill) share one memory port. Each transaction is locked from grant until its data response. A watchdog retires hung transactions with an error.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 256: cycles allowed in ADDR+DATA before forced retirement; 0 disables the watchdog.
- `FIXED_PRIO`, default 0: 0 selects round-robin; 1 makes master 0 always win.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `m0_addr_vld`, `m1_addr_vld`  in  1  request; held until `mX_addr_rsp`.
- `m0_addr`, `m1_addr`  in  32  byte address.
- `m0_op`, `m1_op`  in  1  0 = read, 1 = write.
- `m0_size`, `m1_size`  in  2  memory transfer size encoding (byte / half-word / word).
- `m0_wdata_vld`, `m1_wdata_vld`  in  1  write-data valid.
- `m0_wdata`, `m1_wdata`  in  32  write data.
- `m0_addr_rsp`, `m1_addr_rsp`  out  1  address accepted.
- `m0_data_rsp`, `m1_data_rsp`  out  1  transaction complete; `rdata` valid.
- `m0_rdata`, `m1_rdata`  out  32  read data; 0 when not in the response cycle.
- `m0_err`, `m1_err`  out  1  pulses with `data_rsp` on timeout.
- `mem_addr_vld`, `mem_addr`, `mem_op`, `mem_size`, `mem_wdata_vld`, `mem_wdata`  out  1/32/1/2/1/32  memory side.
- `mem_addr_rsp`, `mem_data_rsp`  in  1  memory responses.
- `mem_rdata`  in  32  memory read data.

## Operation
- States: IDLE, ADDR, DATA. Registered `gnt` (1 bit), `rr_last` (1 bit), `wd_cnt` (watchdog counter, wide enough for `TIMEOUT_CYCLES`).
- IDLE: if any `mX_addr_vld`, pick a winner and register it into `gnt`; go to ADDR; clear `wd_cnt`.
  - Only one requester: it wins.
  - Both requesting, round-robin: the master that is not `rr_last` wins.
  - Both requesting, `FIXED_PRIO`=1: master 0 wins.
- ADDR: forward the granted master's `addr_vld`/`addr`/`op`/`size` to memory. All `mem_*` outputs are 0 outside ADDR/DATA.
  - `mem_addr_rsp` is passed combinationally to the granted `mX_addr_rsp`; state goes to DATA.
  - `mem_addr_rsp` and `mem_data_rsp` in the same cycle: both are forwarded; state goes to IDLE.
  - `mem_data_rsp` without `mem_addr_rsp` is ignored (protocol violation; assertion).
- DATA: forward `wdata_vld`/`wdata` to memory. Keep `mem_addr`/`op`/`size` driven, with `mem_addr_vld`=0.
  - On `mem_data_rsp`: pulse the granted `mX_data_rsp`, present `mem_rdata` on `mX_rdata`, set `rr_last`=`gnt`, go to IDLE.
- Watchdog: `wd_cnt` increments every cycle in ADDR/DATA. When it reaches `TIMEOUT_CYCLES`-1 with no completion:
  - force `mX_addr_rsp` (if still in ADDR), `mX_data_rsp` and `mX_err`, each for 1 cycle, with `rdata`=0;
  - set `mem_addr_vld`=0 and go to IDLE;
  - a `mem_data_rsp` arriving in that same cycle wins (normal completion, no error).
- The non-granted master sees all response outputs at 0 and keeps requesting.
- A requester that drops `addr_vld` in ADDR does not abort the transaction; the arbiter waits (the watchdog bounds the wait).

## Timing
- Reset: state IDLE, `gnt`=0, `rr_last`=1 (master 0 wins first tie), `wd_cnt`=0; every output 0 from the first cycle after the reset edge.
- Arbitration latency: 1 cycle. A request seen in IDLE at cycle N appears on `mem_addr_vld` at N+1.
- Response paths `mem_*_rsp` → `mX_*_rsp`/`rdata` are combinational, 0 added latency.
- Minimum transaction: IDLE + ADDR + DATA = 3 cycles with zero-wait memory; 2 cycles if address and data responses coincide. One IDLE cycle separates transactions.
- `rst` mid-transaction: IDLE next edge; memory-side valids drop; no response is issued to either master.

## Structure
- Put state enum `DmemArbStateType` (IDLE/ADDR/DATA) and the op/size encodings in RV_pkg. Reuse the existing memop/memsize types.
- Flat module, no sub-module. The winner-select function is a local function.

## Test plan
- m0 read `0x100`, memory answers `addr_rsp` +1 cycle and `data_rsp` +2 cycles with `0xDEADBEEF` → `m0_rdata`=`0xDEADBEEF`, `m1_*` all 0, 4 cycles from request to completion.
- m0 and m1 both request continuously, 4 transactions → grants alternate 0,1,0,1; with `FIXED_PRIO`=1, all grants go to m0.
- m1 write `0x200` ← `0x12345678` → `mem_addr`=`0x200`, `mem_op`=1, `mem_wdata`=`0x12345678` in DATA, `m1_data_rsp` 1 cycle.
- Memory asserts `addr_rsp` and `data_rsp` in the same cycle → both forwarded; state back to IDLE after 2 cycles.
- `TIMEOUT_CYCLES`=8, memory silent → `m0_data_rsp`=`m0_err`=1 on the 8th ADDR/DATA cycle, `rdata`=0, next request granted normally.
- `rst` asserted while in DATA → next cycle all outputs 0, state IDLE, the next tie goes to m0.
